seg_scan_ctrl: RTL and testbench

Parametrised multiplexed seven-segment scanner, the successor to the fixed 8-digit hex8 display driver. It drives DIGITS common-select digits from a packed nibble bus and adds several features:
- frame-synchronous shadow loading
- per-digit decimal point, blank and blink
- leading-zero suppression
- lamp-test and off modes
It sits between the lab datapath (counters, FSM state displays) and the board segment and select pins.

---
 rtl/seg_scan_ctrl_pkg.sv | 49 ++++
 rtl/seg_scan_ctrl_if.sv | 30 +++
 rtl/seg_scan_ctrl_decode.sv | 35 +++
 rtl/seg_scan_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/seg_scan_ctrl_pkg.sv
// rtl/seg_scan_ctrl_pkg.sv - shared types, constants and helpers for the seven-segment scanner
// Purpose: display mode encodings, segment constants, hex-to-segment table
//          and a width helper used by seg_scan_ctrl and seg_decode.
// Ports:   none (package).
package seg_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_HEX  = 2'b00,
    MODE_LZS  = 2'b01,
    MODE_TEST = 2'b10,
    MODE_OFF  = 2'b11
  } mode_e;

  // Active-high segment patterns, bit order {dp,g,f,e,d,c,b,a}
  localparam logic [7:0] SEG_OFF = 8'h00;
  localparam logic [7:0] SEG_ALL = 8'hFF;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

  // Bits needed to count 0..value-1; never less than 1 so tiny parameters stay legal
  function automatic int clog2(input int value);
    int r;
    r = 1;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// rtl/seg_scan_ctrl_if.sv - datapath-side bundle of the seven-segment scanner
// Purpose: groups the scan controls, display content and pin outputs.
// Ports (signals):
//   i_en, i_load, i_disp_data[4*DIGITS], i_dp, i_blank, i_blink, i_mode[2]  (to scanner)
//   o_sel[DIGITS], o_seg[8], o_frame_done                                   (from scanner)
// Modports: master = datapath/driver side, slave = scanner side.
interface seg_scan_ctrl_if #(
  parameter int DIGITS = 8
);
  logic                  i_en;
  logic                  i_load;
  logic [4*DIGITS-1:0]   i_disp_data;
  logic [DIGITS-1:0]     i_dp;
  logic [DIGITS-1:0]     i_blank;
  logic [DIGITS-1:0]     i_blink;
  logic [1:0]            i_mode;
  logic [DIGITS-1:0]     o_sel;
  logic [7:0]            o_seg;
  logic                  o_frame_done;

  modport master (
    output i_en, i_load, i_disp_data, i_dp, i_blank, i_blink, i_mode,
    input  o_sel, o_seg, o_frame_done
  );

  modport slave (
    input  i_en, i_load, i_disp_data, i_dp, i_blank, i_blink, i_mode,
    output o_sel, o_seg, o_frame_done
  );
endinterface

// File: rtl/seg_scan_ctrl_decode.sv
// rtl/seg_scan_ctrl_decode.sv - one-digit nibble to active-high segment decoder
// Purpose: turns the selected digit's nibble, dp and dark controls into
//          {dp,g,f,e,d,c,b,a}, active high.
// Ports:
//   i_nibble[4]  digit value
//   i_dp         decimal point
//   i_lamp       lamp test: everything lit
//   i_dark       blank or blink-off: everything dark, dp included
//   i_suppress   leading zero: a..g dark, dp still shown
//   o_seg[8]     active-high segments
module seg_decode
  import seg_scan_ctrl_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_dp,
  input  logic       i_lamp,
  input  logic       i_dark,
  input  logic       i_suppress,
  output logic [7:0] o_seg
);

  always_comb begin
    o_seg = SEG_OFF;
    if (i_lamp) begin
      o_seg = SEG_ALL;
    end else if (i_dark) begin
      o_seg = SEG_OFF;
    end else if (i_suppress) begin
      o_seg = {i_dp, 7'b000_0000};
    end else begin
      o_seg = {i_dp, hex_to_seg(i_nibble)};
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed seven-segment scanner with shadowed content
// Purpose: scans DIGITS common-select digits, SCAN_DIV clocks per digit, with
//          frame-synchronous content commit, blink, leading-zero suppression,
//          lamp test and off modes.
// Ports:
//   i_clk     system clock
//   i_rst_n   asynchronous active-low reset
//   bus       seg_scan_ctrl_if.slave (controls/content in, sel/seg/frame_done out)
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int DIGITS         = 8,
  parameter int SCAN_DIV       = 50000,
  parameter int BLINK_FRAMES   = 250,
  parameter int SEL_ACTIVE_LOW = 1,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  seg_scan_ctrl_if.slave    bus
);

  localparam int IDX_W = clog2(DIGITS);
  localparam int DIV_W = clog2(SCAN_DIV);
  localparam int BLK_W = clog2(BLINK_FRAMES);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

  // Polarity masks; XOR with these happens only at the output registers
  localparam logic [DIGITS-1:0] SEL_INV  = (SEL_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [7:0]        SEG_INV  = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [7:0]        SEG_DARK = SEG_OFF ^ SEG_INV;

  logic [DIV_W-1:0]     r_div;
  logic [IDX_W-1:0]     r_idx;
  logic [BLK_W-1:0]     r_blink_cnt;
  logic                 r_blink_off;

  logic [4*DIGITS-1:0]  r_pend_data;
  logic [DIGITS-1:0]    r_pend_dp;
  logic [DIGITS-1:0]    r_pend_blank;
  logic [DIGITS-1:0]    r_pend_blink;
  logic                 r_pend_vld;

  logic [4*DIGITS-1:0]  r_sh_data;
  logic [DIGITS-1:0]    r_sh_dp;
  logic [DIGITS-1:0]    r_sh_blank;
  logic [DIGITS-1:0]    r_sh_blink;

  logic [DIGITS-1:0]    r_sel;
  logic [7:0]           r_seg;
  logic                 r_frame_done;

  logic                 w_div_last;
  logic                 w_idx_last;
  logic                 w_frame_wrap;
  logic                 w_commit;
  logic [DIGITS-1:0]    w_lz;
  logic [DIGITS-1:0]    w_sel_hot;
  logic [3:0]           w_nibble;
  logic                 w_dp;
  logic                 w_dark;
  logic                 w_suppress;
  logic                 w_lamp;
  logic [7:0]           w_seg;

  assign w_div_last   = (r_div == DIV_LAST);
  assign w_idx_last   = (r_idx == IDX_LAST);
  assign w_frame_wrap = bus.i_en && w_div_last && w_idx_last;
  // While disabled there is no frame to tear, so content commits right away
  assign w_commit     = (w_frame_wrap || !bus.i_en) && (r_pend_vld || bus.i_load);

  // Divider and digit index; both parked at 0 while disabled so a restart
  // begins with a full slot on digit 0
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div <= '0;
      r_idx <= '0;
    end else if (!bus.i_en) begin
      r_div <= '0;
      r_idx <= '0;
    end else if (w_div_last) begin
      r_div <= '0;
      r_idx <= w_idx_last ? '0 : r_idx + 1'b1;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  // Blink phase toggles every BLINK_FRAMES completed frames; starts in the on phase
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_blink_cnt <= '0;
      r_blink_off <= 1'b0;
    end else if (w_frame_wrap) begin
      if (r_blink_cnt == BLK_LAST) begin
        r_blink_cnt <= '0;
        r_blink_off <= ~r_blink_off;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  // Pending register: last Load wins until the next commit
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend_data  <= '0;
      r_pend_dp    <= '0;
      r_pend_blank <= '0;
      r_pend_blink <= '0;
      r_pend_vld   <= 1'b0;
    end else begin
      if (bus.i_load) begin
        r_pend_data  <= bus.i_disp_data;
        r_pend_dp    <= bus.i_dp;
        r_pend_blank <= bus.i_blank;
        r_pend_blink <= bus.i_blink;
      end
      if (w_commit) begin
        r_pend_vld <= 1'b0;
      end else if (bus.i_load) begin
        r_pend_vld <= 1'b1;
      end
    end
  end

  // Shadow register: the only content the display path reads. A Load landing
  // on the commit cycle bypasses the pending stage.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sh_data  <= '0;
      r_sh_dp    <= '0;
      r_sh_blank <= '0;
      r_sh_blink <= '0;
    end else if (w_commit) begin
      if (bus.i_load) begin
        r_sh_data  <= bus.i_disp_data;
        r_sh_dp    <= bus.i_dp;
        r_sh_blank <= bus.i_blank;
        r_sh_blink <= bus.i_blink;
      end else begin
        r_sh_data  <= r_pend_data;
        r_sh_dp    <= r_pend_dp;
        r_sh_blank <= r_pend_blank;
        r_sh_blink <= r_pend_blink;
      end
    end
  end

  // w_lz[i]: digit i and every digit above it are zero
  always_comb begin
    w_lz = '0;
    w_lz[DIGITS-1] = (r_sh_data[4*(DIGITS-1) +: 4] == 4'h0);
    for (int i = DIGITS - 2; i >= 0; i--) begin
      w_lz[i] = w_lz[i+1] && (r_sh_data[4*i +: 4] == 4'h0);
    end
  end

  assign w_sel_hot  = {{(DIGITS-1){1'b0}}, 1'b1} << r_idx;
  assign w_nibble   = r_sh_data[4*r_idx +: 4];
  assign w_dp       = r_sh_dp[r_idx];
  assign w_dark     = r_sh_blank[r_idx] || (r_blink_off && r_sh_blink[r_idx]);
  assign w_suppress = (bus.i_mode == MODE_LZS) && w_lz[r_idx] && (r_idx != '0);
  assign w_lamp     = (bus.i_mode == MODE_TEST);

  seg_decode u_decode (
    .i_nibble   (w_nibble),
    .i_dp       (w_dp),
    .i_lamp     (w_lamp),
    .i_dark     (w_dark),
    .i_suppress (w_suppress),
    .o_seg      (w_seg)
  );

  // Output registers: Sel and Seg are both loaded from the same index, so
  // exactly one select is active with matching segments and no dark gap
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sel        <= SEL_INV;
      r_seg        <= SEG_DARK;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_frame_wrap;
      if (!bus.i_en || (bus.i_mode == MODE_OFF)) begin
        r_sel <= SEL_INV;
        r_seg <= SEG_DARK;
      end else begin
        r_sel <= w_sel_hot ^ SEL_INV;
        r_seg <= w_seg ^ SEG_INV;
      end
    end
  end

  assign bus.o_sel        = r_sel;
  assign bus.o_seg        = r_seg;
  assign bus.o_frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - self-checking bench for seg_scan_ctrl
module tb_seg_scan_ctrl;

  localparam int DIGITS       = 8;
  localparam int SCAN_DIV     = 4;
  localparam int BLINK_FRAMES = 2;
  localparam int FRAME        = SCAN_DIV * DIGITS;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg_scan_ctrl_if #(.DIGITS(DIGITS)) bus ();

  seg_scan_ctrl #(
    .DIGITS         (DIGITS),
    .SCAN_DIV       (SCAN_DIV),
    .BLINK_FRAMES   (BLINK_FRAMES),
    .SEL_ACTIVE_LOW (1),
    .SEG_ACTIVE_LOW (1)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: content as whole values, position as elapsed enabled cycles
  logic [6:0] hex7 [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  int          m_cyc, m_frames;
  bit          m_pv;
  logic [31:0] p_data, s_data;
  logic [7:0]  p_dp, p_bl, p_bk, s_dp, s_bl, s_bk;
  logic [7:0]  exp_sel, exp_seg;
  logic        exp_fd;

  task automatic model_reset();
    m_cyc = 0; m_frames = 0; m_pv = 0;
    p_data = 0; p_dp = 0; p_bl = 0; p_bk = 0;
    s_data = 0; s_dp = 0; s_bl = 0; s_bk = 0;
    exp_sel = 8'hFF; exp_seg = 8'hFF; exp_fd = 0;
  endtask

  // Pin value (active low) for digit d in a non-off mode
  function automatic logic [7:0] ref_seg(input int d, input logic [1:0] mode);
    logic [7:0] s;
    int hi;
    bit blink_off;
    blink_off = ((m_frames / BLINK_FRAMES) % 2) == 1;
    hi = 0;
    for (int i = 0; i < DIGITS; i++)
      if (((s_data >> (4 * i)) & 32'hF) != 0) hi = i;
    if (mode == 2'b10) begin
      s = 8'hFF;
    end else if (s_bl[d] || (blink_off && s_bk[d])) begin
      s = 8'h00;
    end else begin
      s = {s_dp[d], 7'h00};
      if (!(mode == 2'b01 && d > hi)) s[6:0] = hex7[(s_data >> (4 * d)) & 32'hF];
    end
    return ~s;
  endfunction

  task automatic model_step();
    bit wrap;
    int d;
    wrap = 0;
    if (bus.i_en) begin
      d = (m_cyc / SCAN_DIV) % DIGITS;
      if (bus.i_mode == 2'b11) begin
        exp_sel = 8'hFF; exp_seg = 8'hFF;
      end else begin
        exp_sel = ~(8'h01 << d);
        exp_seg = ref_seg(d, bus.i_mode);
      end
      wrap = (m_cyc % FRAME) == FRAME - 1;
      m_cyc++;
    end else begin
      m_cyc = 0; exp_sel = 8'hFF; exp_seg = 8'hFF;
    end
    exp_fd = wrap;
    if (wrap) m_frames++;
    if ((wrap || !bus.i_en) && (m_pv || bus.i_load)) begin
      if (bus.i_load) begin
        s_data = bus.i_disp_data; s_dp = bus.i_dp; s_bl = bus.i_blank; s_bk = bus.i_blink;
      end else begin
        s_data = p_data; s_dp = p_dp; s_bl = p_bl; s_bk = p_bk;
      end
      m_pv = 0;
    end else if (bus.i_load) begin
      m_pv = 1;
    end
    if (bus.i_load) begin
      p_data = bus.i_disp_data; p_dp = bus.i_dp; p_bl = bus.i_blank; p_bk = bus.i_blink;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("sel", bus.o_sel, exp_sel);
    check("seg", bus.o_seg, exp_seg);
    check("frame_done", bus.o_frame_done, exp_fd);
  endtask

  task automatic load(input logic [31:0] data, input logic [7:0] dp, input logic [7:0] bl,
                      input logic [7:0] bk);
    bus.i_disp_data = data; bus.i_dp = dp; bus.i_blank = bl; bus.i_blink = bk;
    bus.i_load = 1'b1;
    tick();
    bus.i_load = 1'b0;
  endtask

  task automatic wait_fd();
    for (int k = 0; k < 2 * FRAME && bus.o_frame_done !== 1'b1; k++) tick();
    check("frame_done_seen", bus.o_frame_done, 1'b1);
  endtask

  task automatic wait_sel(input logic [7:0] target);
    for (int k = 0; k < 2 * FRAME && bus.o_sel !== target; k++) tick();
    check("sel_reached", bus.o_sel, target);
  endtask

  task automatic rand_inputs();
    bus.i_load = ($urandom_range(0, 5) == 0);
    bus.i_disp_data = $urandom >> $urandom_range(0, 31);
    bus.i_dp = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
    bus.i_blank = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
    bus.i_blink = 8'($urandom);
    if ($urandom_range(0, 63) == 0) bus.i_mode = 2'($urandom);
    if (!bus.i_en) bus.i_en = ($urandom_range(0, 3) == 0);
    else if ($urandom_range(0, 199) == 0) bus.i_en = 1'b0;
  endtask

  initial begin
    bus.i_en = 0; bus.i_load = 0; bus.i_disp_data = 0; bus.i_dp = 0;
    bus.i_blank = 0; bus.i_blink = 0; bus.i_mode = 2'b00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_sel", bus.o_sel, 8'hFF);
    check("rst_seg", bus.o_seg, 8'hFF);
    check("rst_fd", bus.o_frame_done, 1'b0);
    rst_n = 1'b1;

    // Single digit 1 in hex mode
    bus.i_en = 1'b1;
    load(32'h0000_0001, 8'h00, 8'h00, 8'h00);
    wait_fd();
    wait_sel(8'hFE);
    check("t1_dig0", bus.o_seg, 8'hF9);
    wait_sel(8'hFD);
    check("t1_dig1", bus.o_seg, 8'hC0);

    // Leading-zero suppression
    bus.i_mode = 2'b01;
    load(32'h0000_0010, 8'h00, 8'h00, 8'h00);
    wait_fd();
    wait_sel(8'hFE);
    check("lzs_dig0", bus.o_seg, 8'hC0);
    wait_sel(8'hFD);
    check("lzs_dig1", bus.o_seg, 8'hF9);
    wait_sel(8'h7F);
    check("lzs_dig7", bus.o_seg, 8'hFF);

    // Mid-frame load shows only from the next frame
    bus.i_mode = 2'b00;
    wait_fd();
    repeat (10) tick();
    load(32'h1234_5678, 8'h00, 8'h00, 8'h00);
    repeat (3 * FRAME) tick();
    wait_sel(8'hFE);
    check("mid_dig0", bus.o_seg, 8'h80);
    wait_sel(8'h7F);
    check("mid_dig7", bus.o_seg, 8'hF9);

    // Blink on digit 0
    load(32'h0, 8'h00, 8'h00, 8'h01);
    repeat (5 * FRAME) tick();

    // Lamp test overrides blank, then off mode
    bus.i_mode = 2'b10;
    load(32'h0, 8'h00, 8'hFF, 8'h00);
    repeat (FRAME + 2) tick();
    check("lamp_seg", bus.o_seg, 8'h00);
    bus.i_mode = 2'b11;
    repeat (FRAME + 2) tick();
    check("off_sel", bus.o_sel, 8'hFF);

    // Enable drop at digit 5 and restart
    bus.i_mode = 2'b00;
    wait_sel(8'hDF);
    bus.i_en = 1'b0;
    tick();
    check("dis_sel", bus.o_sel, 8'hFF);
    tick();
    bus.i_en = 1'b1;
    for (int k = 0; k < SCAN_DIV; k++) begin
      tick();
      check("restart_dig0", bus.o_sel, 8'hFE);
    end
    tick();
    check("restart_dig1", bus.o_sel, 8'hFD);

    // Randomized run with one asynchronous mid-scan reset
    for (int n = 0; n < 3000; n++) begin
      rand_inputs();
      tick();
      if (n == 1500) begin
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_sel", bus.o_sel, 8'hFF);
        check("async_rst_seg", bus.o_seg, 8'hFF);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
